// File: rtl/reducer_window.sv
// Multi-channel windowed reducer (sum/min/max over WIN_LEN samples per channel).
// Optional feature macro: REDUCER_SAT_EN (saturating sum instead of wrapping).

module reducer_window_ch #(
    parameter int ACC_WIDTH = 40,
    parameter int WIN_LEN   = 8,
    parameter int CNT_W     = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        hit,
    input  logic [1:0]                  op_in,
    input  logic signed [ACC_WIDTH-1:0] sample,
    output logic                        done,
    output logic signed [ACC_WIDTH-1:0] result
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_LEN - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]            cnt;
    logic [1:0]                  op;

    logic                        first;
    logic [1:0]                  eff_op;
    logic signed [ACC_WIDTH-1:0] sum_w, sum_v, red;

    assign first = (cnt == '0);
    assign sum_w = acc + sample;

`ifdef REDUCER_SAT_EN
    // Overflow only when both operands share a sign and the sum flips it.
    logic ovf_pos, ovf_neg;
    assign ovf_pos = !acc[ACC_WIDTH-1] && !sample[ACC_WIDTH-1] &&  sum_w[ACC_WIDTH-1];
    assign ovf_neg =  acc[ACC_WIDTH-1] &&  sample[ACC_WIDTH-1] && !sum_w[ACC_WIDTH-1];
    assign sum_v   = ovf_pos ? ACC_MAX : (ovf_neg ? ACC_MIN : sum_w);
`else
    assign sum_v   = sum_w;
`endif

    always_comb begin
        eff_op = first ? op_in : op;
        case (eff_op)
            2'd1:    red = (sample < acc) ? sample : acc;
            2'd2:    red = (sample > acc) ? sample : acc;
            default: red = sum_v;
        endcase
        result = first ? sample : red;
    end

    assign done = hit && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            cnt <= '0;
            op  <= 2'd0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
            op  <= 2'd0;
        end else if (hit) begin
            acc <= result;
            cnt <= done ? '0 : cnt + 1'b1;
            if (first) op <= op_in;
        end
    end
endmodule

module reducer_window #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40,
    parameter int CH_NUM    = 4,
    parameter int WIN_LEN   = 8,
    localparam int CH_IDW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    localparam int CNT_W    = $clog2(WIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear_i,
    input  logic [1:0]           op_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH_IDW-1:0]    in_ch,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_IDW-1:0]    out_ch,
    output logic [ACC_WIDTH-1:0] out_data
);
    localparam logic [CH_IDW:0] CH_LIM = (CH_IDW + 1)'(CH_NUM);

    logic                               accept, ch_ok;
    logic signed [ACC_WIDTH-1:0]        in_sext;
    logic [CH_NUM-1:0]                  done;
    logic [CH_NUM-1:0][ACC_WIDTH-1:0]   results;
    logic [ACC_WIDTH-1:0]               sel;
    logic                               done_any;

    assign in_ready = !clear_i && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    // Out-of-range channel ids are consumed but touch no channel.
    assign ch_ok    = ({1'b0, in_ch} < CH_LIM);
    assign in_sext  = ACC_WIDTH'($signed(in_data));

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        reducer_window_ch #(
            .ACC_WIDTH(ACC_WIDTH),
            .WIN_LEN  (WIN_LEN),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .clear  (clear_i),
            .hit    (accept && ch_ok && (in_ch == CH_IDW'(g))),
            .op_in  (op_i),
            .sample (in_sext),
            .done   (done[g]),
            .result (results[g])
        );
    end

    // At most one channel can complete per cycle, so an OR-style mux suffices.
    always_comb begin
        sel = '0;
        for (int i = 0; i < CH_NUM; i++)
            if (done[i]) sel = results[i];
        done_any = |done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else if (clear_i) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else if (done_any) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_data  <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_reducer_window.sv
// Directed bench for reducer_window: wide 4-lane DUT, narrow 8-bit DUT, WIN_LEN=1 DUT.
module tb_reducer_window;
    logic        clk = 1'b0;
    logic        reset_n, clear_i, out_ready;
    logic [1:0]  op_i, in_ch;
    logic [31:0] in_data;
    logic        iv_m, iv_n, iv_o;

    logic        rdy_m, vld_m; logic [1:0] ch_m; logic [39:0] dat_m;
    logic        rdy_n, vld_n; logic [1:0] ch_n; logic [7:0]  dat_n;
    logic        rdy_o, vld_o; logic [1:0] ch_o; logic [39:0] dat_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reducer_window #(.WIDTH(32), .ACC_WIDTH(40), .CH_NUM(4), .WIN_LEN(4)) u_m (
        .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .op_i(op_i),
        .in_valid(iv_m), .in_ready(rdy_m), .in_ch(in_ch), .in_data(in_data),
        .out_valid(vld_m), .out_ready(out_ready), .out_ch(ch_m), .out_data(dat_m));

    reducer_window #(.WIDTH(8), .ACC_WIDTH(8), .CH_NUM(4), .WIN_LEN(4)) u_n (
        .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .op_i(op_i),
        .in_valid(iv_n), .in_ready(rdy_n), .in_ch(in_ch), .in_data(in_data[7:0]),
        .out_valid(vld_n), .out_ready(out_ready), .out_ch(ch_n), .out_data(dat_n));

    // CH_NUM=3 leaves id 3 encodable but out of range.
    reducer_window #(.WIDTH(32), .ACC_WIDTH(40), .CH_NUM(3), .WIN_LEN(1)) u_o (
        .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .op_i(op_i),
        .in_valid(iv_o), .in_ready(rdy_o), .in_ch(in_ch), .in_data(in_data),
        .out_valid(vld_o), .out_ready(out_ready), .out_ch(ch_o), .out_data(dat_o));

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [1:0] op, input logic [1:0] ch, input logic [31:0] v);
        op_i = op; in_ch = ch; in_data = v;
        iv_m = (d == 0); iv_n = (d == 1); iv_o = (d == 2);
        @(posedge clk); #1;
        iv_m = 1'b0; iv_n = 1'b0; iv_o = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; clear_i = 1'b0; out_ready = 1'b1;
        op_i = 2'd0; in_ch = 2'd0; in_data = 32'd0;
        iv_m = 1'b0; iv_n = 1'b0; iv_o = 1'b0;
        #12;
        chk("rst_vld", vld_m, 0);
        chk("rst_ch", ch_m, 0);
        chk("rst_data", dat_m, 0);
        chk("rst_rdy", rdy_m, 1);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Sum window on ch0, then a fresh window
        push(0, 2'd0, 2'd0, 1); push(0, 2'd0, 2'd0, 2); push(0, 2'd0, 2'd0, 3);
        chk("sum_early", vld_m, 0);
        push(0, 2'd0, 2'd0, 4);
        chk("sum_vld", vld_m, 1);
        chk("sum_ch", ch_m, 0);
        chk("sum_data", $signed(dat_m), 10);
        push(0, 2'd0, 2'd0, 5);
        chk("sum_consumed", vld_m, 0);
        push(0, 2'd0, 2'd0, 5); push(0, 2'd0, 2'd0, 5); push(0, 2'd0, 2'd0, 5);
        chk("sum2_data", $signed(dat_m), 20);

        // Interleaved max (ch1) / min (ch2); later op_i values must be ignored
        push(0, 2'd2, 2'd1, -5); push(0, 2'd1, 2'd2, -5);
        push(0, 2'd0, 2'd1, 7);  push(0, 2'd0, 2'd2, 7);
        push(0, 2'd0, 2'd1, 3);  push(0, 2'd3, 2'd2, 3);
        push(0, 2'd0, 2'd1, -1);
        chk("max_ch", ch_m, 1);
        chk("max_data", $signed(dat_m), 7);
        push(0, 2'd0, 2'd2, -1);
        chk("min_ch", ch_m, 2);
        chk("min_data", $signed(dat_m), -5);
        @(posedge clk); #1;
        chk("idle_vld", vld_m, 0);

        // Backpressure: ch0 completes and is held, ch3 completion waits
        out_ready = 1'b0;
        push(0, 2'd0, 2'd0, 1); push(0, 2'd0, 2'd3, 2);
        push(0, 2'd0, 2'd0, 1); push(0, 2'd0, 2'd3, 2);
        push(0, 2'd0, 2'd0, 1); push(0, 2'd0, 2'd3, 2);
        push(0, 2'd0, 2'd0, 1);
        chk("bp_vld", vld_m, 1);
        chk("bp_rdy_low", rdy_m, 0);
        op_i = 2'd0; in_ch = 2'd3; in_data = 2; iv_m = 1'b1;
        @(posedge clk); #1; @(posedge clk); #1;
        chk("bp_hold_ch", ch_m, 0);
        chk("bp_hold_data", $signed(dat_m), 4);
        chk("bp_hold_vld", vld_m, 1);
        out_ready = 1'b1; #1;
        chk("bp_rdy_high", rdy_m, 1);
        @(posedge clk); #1; iv_m = 1'b0;
        chk("bp2_ch", ch_m, 3);
        chk("bp2_data", $signed(dat_m), 8);
        @(posedge clk); #1;
        chk("bp_drained", vld_m, 0);

        // Async reset mid-window while a result is held
        out_ready = 1'b0;
        push(0, 2'd0, 2'd0, 2); push(0, 2'd0, 2'd0, 3);
        push(0, 2'd0, 2'd1, 1); push(0, 2'd0, 2'd1, 1);
        push(0, 2'd0, 2'd1, 1); push(0, 2'd0, 2'd1, 1);
        chk("pre_rst_vld", vld_m, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_vld", vld_m, 0);
        chk("async_rst_data", dat_m, 0);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        push(0, 2'd0, 2'd0, 1); push(0, 2'd0, 2'd0, 1);
        push(0, 2'd0, 2'd0, 1); push(0, 2'd0, 2'd0, 1);
        chk("post_rst_data", $signed(dat_m), 4);

        // clear_i blocks acceptance and wipes partial windows
        push(0, 2'd0, 2'd2, 10);
        clear_i = 1'b1; in_ch = 2'd2; in_data = 100; iv_m = 1'b1; #1;
        chk("clr_rdy", rdy_m, 0);
        @(posedge clk); #1;
        clear_i = 1'b0; iv_m = 1'b0;
        chk("clr_vld", vld_m, 0);
        push(0, 2'd0, 2'd2, 1); push(0, 2'd0, 2'd2, 1);
        push(0, 2'd0, 2'd2, 1); push(0, 2'd0, 2'd2, 1);
        chk("clr_sum", $signed(dat_m), 4);
        chk("clr_ch", ch_m, 2);

        // WIN_LEN=1 emits each sample; out-of-range channel is swallowed
        push(2, 2'd0, 2'd1, 9);
        chk("w1_vld", vld_o, 1);
        chk("w1_ch", ch_o, 1);
        chk("w1_data", $signed(dat_o), 9);
        push(2, 2'd1, 2'd0, -3);
        chk("w1_neg", $signed(dat_o), -3);
        op_i = 2'd0; in_ch = 2'd3; in_data = 77; iv_o = 1'b1; #1;
        chk("badch_rdy", rdy_o, 1);
        @(posedge clk); #1; iv_o = 1'b0;
        chk("badch_vld", vld_o, 0);

        // 8-bit accumulator overflow behaviour
        repeat (4) push(1, 2'd0, 2'd0, 100);
        chk("ovf_pos_vld", vld_n, 1);
`ifdef REDUCER_SAT_EN
        chk("ovf_pos", $signed(dat_n), 127);
`else
        chk("ovf_pos", $signed(dat_n), -112);
`endif
        repeat (4) push(1, 2'd0, 2'd0, -100);
`ifdef REDUCER_SAT_EN
        chk("ovf_neg", $signed(dat_n), -128);
`else
        chk("ovf_neg", $signed(dat_n), 112);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
